sp_ram_master: RTL and testbench

Bus-side initiator for the synchronous single-port RAM (`single_port_sync_ram`). It turns a valid/ready request stream (read or write) into correctly sequenced `cs`/`we`/`oe`/`addr` cycles on the RAM's shared bidirectional `data` bus, and returns read data on a valid/ready response channel. It sits between any client logic (DMA, CPU port, test sequencer) and the RAM, replacing hand-driven bus stimulus.

---
 rtl/sp_ram_pkg.sv | 16 +
 rtl/sp_ram_bus_drv.sv | 70 +++++++
 rtl/sp_ram_master.sv | 110 +++++++++++
 tb/tb_sp_ram_master.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// Shared types for the single-port RAM initiator: FSM state set and op encoding.
package sp_ram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RESP,
    ST_ERR_RESP
  } sp_ram_state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/sp_ram_bus_drv.sv
// Registered RAM bus outputs, tri-state data driver and read-data capture.
module sp_ram_bus_drv #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_d,
  input  logic                  we_d,
  input  logic                  oe_d,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic                  cap_en,
  input  logic                  clr,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  cs,
  output logic                  we,
  output logic                  oe,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic                  cs_q, we_q, oe_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (load) begin
      addr_d  = addr_in;
      wdata_d = wdata_in;
    end
    if (clr) begin
      rdata_d = '0;
    end else if (cap_en) begin
      rdata_d = data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cs_q    <= cs_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Drive-enable is the registered we, so the RAM (which drives only with we=0) never collides.
  assign data  = we_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign addr  = addr_q;
  assign cs    = cs_q;
  assign we    = we_q;
  assign oe    = oe_q;
  assign rdata = rdata_q;

endmodule

// File: rtl/sp_ram_master.sv
// Valid/ready initiator for a synchronous single-port RAM: request FSM and response channel.
module sp_ram_master
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  cs,
  output logic                  we,
  output logic                  oe,
  inout  wire  [DATA_WIDTH-1:0] data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  sp_ram_state_e state_q, state_d;
  logic          op_q, op_d;
  logic          accept, in_range, load, clr, cap_en;
  logic          cs_d, we_d, oe_d;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    req_ready = (state_q == ST_IDLE);
    accept    = req_valid & req_ready;
    in_range  = ({1'b0, req_addr} < DEPTH_W);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = req_we;
          if (!in_range)                state_d = ST_ERR_RESP;
          else if (req_we == OP_WRITE)  state_d = ST_WR;
          else                          state_d = ST_RD_ADDR;
        end
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      ST_ERR_RESP: begin
        // Out-of-range writes are dropped silently; only reads owe a response.
        if (op_q == OP_READ) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          if (rsp_ready) state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    load   = accept & in_range;
    clr    = accept & ~in_range;
    cap_en = (state_q == ST_RD_DATA);
    cs_d   = (state_d == ST_WR) || (state_d == ST_RD_ADDR) || (state_d == ST_RD_DATA);
    we_d   = (state_d == ST_WR);
    oe_d   = (state_d == ST_RD_ADDR) || (state_d == ST_RD_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  sp_ram_bus_drv #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bus_drv (
    .clk     (clk),
    .rst     (rst),
    .cs_d    (cs_d),
    .we_d    (we_d),
    .oe_d    (oe_d),
    .load    (load),
    .addr_in (req_addr),
    .wdata_in(req_wdata),
    .cap_en  (cap_en),
    .clr     (clr),
    .addr    (addr),
    .cs      (cs),
    .we      (we),
    .oe      (oe),
    .data    (data),
    .rdata   (rsp_rdata)
  );

endmodule

// File: tb/tb_sp_ram_master.sv
// Randomized bench: two masters (DEPTH 16 and 12) each on a behavioural RAM, checked against a word-array model.
module tb_sp_ram_master;

  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    req_valid, rsp_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_ready, rsp_valid, rsp_err, cs, we, oe;
  logic [DW-1:0] rsp_rdata0, rsp_rdata1;
  logic [AW-1:0] addr0, addr1;
  wire  [DW-1:0] data0, data1;

  sp_ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(16)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err[0]), .addr(addr0), .cs(cs[0]), .we(we[0]), .oe(oe[0]), .data(data0)
  );

  sp_ram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(12)) u_dut12 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err[1]), .addr(addr1), .cs(cs[1]), .we(we[1]), .oe(oe[1]), .data(data1)
  );

  // Synchronous single-port RAMs: registered read, data driven while cs & oe & !we.
  logic [DW-1:0] ram0 [16];
  logic [DW-1:0] ram1 [16];
  logic [DW-1:0] rdq0, rdq1;
  always @(posedge clk) begin
    if (cs[0] & we[0])  ram0[addr0] <= data0;
    if (cs[0] & ~we[0]) rdq0 <= ram0[addr0];
    if (cs[1] & we[1])  ram1[addr1] <= data1;
    if (cs[1] & ~we[1]) rdq1 <= ram1[addr1];
  end
  assign data0 = (cs[0] & oe[0] & ~we[0]) ? rdq0 : {DW{1'bz}};
  assign data1 = (cs[1] & oe[1] & ~we[1]) ? rdq1 : {DW{1'bz}};

  logic          sel;
  wire           s_ready = sel ? req_ready[1] : req_ready[0];
  wire           s_valid = sel ? rsp_valid[1] : rsp_valid[0];
  wire           s_err   = sel ? rsp_err[1]   : rsp_err[0];
  wire           s_cs    = sel ? cs[1] : cs[0];
  wire           s_we    = sel ? we[1] : we[0];
  wire           s_oe    = sel ? oe[1] : oe[0];
  wire [AW-1:0]  s_addr  = sel ? addr1 : addr0;
  wire [DW-1:0]  s_rdata = sel ? rsp_rdata1 : rsp_rdata0;
  wire [DW-1:0]  s_data  = sel ? data1 : data0;

  logic [DW-1:0] ref_mem [2][16];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (dut%0d, t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  function automatic int depth_of(input logic s);
    return s ? 12 : 16;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(s_ready), 32'd1);
  endtask

  // All tasks start and end just after a falling edge.
  task automatic do_write(input int a, input logic [DW-1:0] d);
    logic ok;
    ok        = (a < depth_of(sel));
    req_we    = 1'b1;
    req_addr  = AW'(a);
    req_wdata = d;
    req_valid = '0;
    req_valid[sel] = 1'b1;
    wait_ready("wr_accept");
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("wr_cs", 32'(s_cs), 32'(ok));
    chk("wr_we", 32'(s_we), 32'(ok));
    chk("wr_no_rsp", 32'(s_valid), 32'd0);
    if (ok) begin
      chk("wr_addr", 32'(s_addr), 32'(a));
      chk("wr_data", s_data, d);
      ref_mem[sel][a] = d;
    end
    @(negedge clk);
    chk("wr_cs_one_cycle", 32'(s_cs), 32'd0);
    chk("wr_ready_back", 32'(s_ready), 32'd1);
  endtask

  task automatic do_read(input int a, input int hold, input bit early);
    logic ok;
    logic [DW-1:0] exp_d;
    int n;
    ok        = (a < depth_of(sel));
    exp_d     = ok ? ref_mem[sel][a] : '0;
    req_we    = 1'b0;
    req_addr  = AW'(a);
    req_valid = '0;
    req_valid[sel] = 1'b1;
    rsp_ready = '0;
    if (early) rsp_ready[sel] = 1'b1;
    wait_ready("rd_accept");
    @(posedge clk);
    #1 req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_valid && n < 10);
    chk("rd_latency", 32'(n), ok ? 32'd3 : 32'd1);
    chk("rd_data", s_rdata, exp_d);
    chk("rd_err", 32'(s_err), 32'(!ok));
    chk("rd_busy", 32'(s_ready), 32'd0);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("rd_hold_valid", 32'(s_valid), 32'd1);
        chk("rd_hold_data", s_rdata, exp_d);
        chk("rd_hold_busy", 32'(s_ready), 32'd0);
      end
      rsp_ready[sel] = 1'b1;
    end
    @(posedge clk);
    #1 rsp_ready = '0;
    @(negedge clk);
    chk("rd_single_rsp", 32'(s_valid), 32'd0);
    chk("rd_idle", 32'(s_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] wd [4];
    rst = 1'b1; sel = 1'b0;
    req_valid = '0; rsp_ready = '0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      chk("rst_cs", 32'(s_cs), 32'd0);
      chk("rst_we", 32'(s_we), 32'd0);
      chk("rst_oe", 32'(s_oe), 32'd0);
      chk("rst_addr", 32'(s_addr), 32'd0);
      chk("rst_rsp_valid", 32'(s_valid), 32'd0);
      chk("rst_rsp_rdata", s_rdata, 32'd0);
      chk("rst_rsp_err", 32'(s_err), 32'd0);
      chk("rst_req_ready", 32'(s_ready), 32'd1);
    end

    // Directed write/read pair.
    sel = 1'b0;
    do_write(2, 32'd52);
    do_write(3, 32'd20);
    do_read(2, 0, 1'b0);
    do_read(3, 0, 1'b0);

    // Back-to-back writes with req_valid held high.
    for (int k = 0; k < 4; k++) wd[k] = $urandom;
    req_we = 1'b1;
    req_valid = 2'b01;
    for (int k = 0; k < 4; k++) begin
      req_addr  = AW'(8 + k);
      req_wdata = wd[k];
      chk("b2b_ready_hi", 32'(s_ready), 32'd1);
      @(posedge clk);
      #1 if (k == 3) req_valid = '0;
      @(negedge clk);
      chk("b2b_ready_lo", 32'(s_ready), 32'd0);
      chk("b2b_cs", 32'(s_cs), 32'd1);
      chk("b2b_data", s_data, wd[k]);
      ref_mem[0][8 + k] = wd[k];
      @(negedge clk);
    end
    do_write(9, $urandom);
    do_read(9, 0, 1'b0);

    // Stalled response.
    do_write(5, $urandom);
    do_read(5, 6, 1'b0);

    // Out-of-range handling on the 12-word instance.
    sel = 1'b1;
    do_write(11, $urandom);
    do_write(13, 32'hDEAD);
    do_read(13, 2, 1'b0);
    do_read(11, 0, 1'b0);

    // Reset in the RD_DATA cycle.
    sel = 1'b0;
    req_we = 1'b0; req_addr = AW'(2); req_valid = 2'b01;
    wait_ready("rst_rd_accept");
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rd_oe_before", 32'(s_oe), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_cs", 32'(s_cs), 32'd0);
    chk("rst_mid_oe", 32'(s_oe), 32'd0);
    chk("rst_mid_we", 32'(s_we), 32'd0);
    chk("rst_mid_rsp_valid", 32'(s_valid), 32'd0);
    chk("rst_mid_ready", 32'(s_ready), 32'd1);
    do_read(2, 0, 1'b0);

    // Fill every address with random data on both instances, read back including the 15->0 wrap.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int a = 0; a < 16; a++) do_write(a, $urandom);
      for (int a = 0; a < 16; a++) do_read(a, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      do_read(0, 0, 1'b0);
    end

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) do_write(int'($urandom_range(0, 15)), $urandom);
      else do_read(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
